// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_unit
//  Brief    : Instruction-fetch stage with a credit-limited prefetch FIFO.
//  Revision : 1.0
// ============================================================================
module if_prefetch_unit #(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0,
    parameter logic [31:0] TRAP_VEC  = 32'h64,
    parameter int          PC_INC    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trap,
    input  logic          jr,
    input  logic          j,
    input  logic          br_taken,
    input  logic [AW-1:0] jr_addr,
    input  logic [AW-1:0] jump_addr,
    input  logic [AW-1:0] branch_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] nextpc_out
);

    localparam int              c_ptr_w    = $clog2(DEPTH);
    localparam int              c_cnt_w    = c_ptr_w + 1;
    localparam logic [AW-1:0]   c_reset_pc = AW'(RESET_VEC);
    localparam logic [AW-1:0]   c_trap_pc  = AW'(TRAP_VEC);
    localparam logic [AW-1:0]   c_pc_inc   = AW'(PC_INC);
    localparam logic [c_cnt_w:0] c_depth   = (c_cnt_w + 1)'(DEPTH);

    logic [AW-1:0]      r_fetch_pc_q,    w_fetch_pc_d;
    logic [c_cnt_w-1:0] r_count_q,       w_count_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q,      w_rd_ptr_d;
    logic [c_ptr_w-1:0] r_wr_ptr_q,      w_wr_ptr_d;
    logic               r_inflight_q,    w_inflight_d;
    logic [AW-1:0]      r_inflight_pc_q, w_inflight_pc_d;

    logic [AW-1:0] r_pc_mem_q    [DEPTH];
    logic [AW-1:0] w_pc_mem_d    [DEPTH];
    logic [AW-1:0] r_npc_mem_q   [DEPTH];
    logic [AW-1:0] w_npc_mem_d   [DEPTH];
    logic [DW-1:0] r_instr_mem_q [DEPTH];
    logic [DW-1:0] w_instr_mem_d [DEPTH];

    logic             w_redirect;
    logic [AW-1:0]    w_target;
    logic [c_cnt_w:0] w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_redirect = trap | jr | j | br_taken;
        w_target   = branch_addr;
        if (trap) begin
            w_target = c_trap_pc;
        end else if (jr) begin
            w_target = jr_addr;
        end else if (j) begin
            w_target = jump_addr;
        end
    end

    // Entries already buffered plus the one in flight must fit, so a stalled
    // decode can never cause an overflow.
    always_comb begin
        w_occupancy = {1'b0, r_count_q} + {{c_cnt_w{1'b0}}, r_inflight_q};
        w_issue     = !reset && !w_redirect && (w_occupancy < c_depth);
        w_push      = r_inflight_q && !w_redirect;
        w_pop       = (r_count_q != '0) && ready_in && !w_redirect;
    end

    always_comb begin
        w_fetch_pc_d    = r_fetch_pc_q;
        w_count_d       = r_count_q;
        w_rd_ptr_d      = r_rd_ptr_q;
        w_wr_ptr_d      = r_wr_ptr_q;
        w_inflight_d    = r_inflight_q;
        w_inflight_pc_d = r_inflight_pc_q;
        w_pc_mem_d      = r_pc_mem_q;
        w_npc_mem_d     = r_npc_mem_q;
        w_instr_mem_d   = r_instr_mem_q;

        if (w_redirect) begin
            w_fetch_pc_d = w_target;
            w_count_d    = '0;
            w_rd_ptr_d   = '0;
            w_wr_ptr_d   = '0;
            w_inflight_d = 1'b0;
        end else begin
            if (w_issue) begin
                w_fetch_pc_d    = r_fetch_pc_q + c_pc_inc;
                w_inflight_pc_d = r_fetch_pc_q;
            end
            w_inflight_d = w_issue;
            if (w_push) begin
                w_pc_mem_d[r_wr_ptr_q]    = r_inflight_pc_q;
                w_npc_mem_d[r_wr_ptr_q]   = r_inflight_pc_q + c_pc_inc;
                w_instr_mem_d[r_wr_ptr_q] = imem_rdata;
                w_wr_ptr_d                = r_wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
            end
            w_count_d = r_count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc_q    <= c_reset_pc;
            r_count_q       <= '0;
            r_rd_ptr_q      <= '0;
            r_wr_ptr_q      <= '0;
            r_inflight_q    <= 1'b0;
            r_inflight_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem_q[i]    <= '0;
                r_npc_mem_q[i]   <= '0;
                r_instr_mem_q[i] <= '0;
            end
        end else begin
            r_fetch_pc_q    <= w_fetch_pc_d;
            r_count_q       <= w_count_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_wr_ptr_q      <= w_wr_ptr_d;
            r_inflight_q    <= w_inflight_d;
            r_inflight_pc_q <= w_inflight_pc_d;
            r_pc_mem_q      <= w_pc_mem_d;
            r_npc_mem_q     <= w_npc_mem_d;
            r_instr_mem_q   <= w_instr_mem_d;
        end
    end

    always_comb begin
        imem_req   = w_issue;
        imem_addr  = r_fetch_pc_q;
        valid_out  = (r_count_q != '0);
        instr_out  = r_instr_mem_q[r_rd_ptr_q];
        pc_out     = r_pc_mem_q[r_rd_ptr_q];
        nextpc_out = r_npc_mem_q[r_rd_ptr_q];
    end

endmodule
`default_nettype wire
